matrix_frame_scheduler: RTL and testbench

- Sequences one complete APA102-style refresh of the 8x8 LED matrix: one start word, 64 pixel words, then END_WORDS end words.
- Each pixel word is the foreground or background colour, selected by a 64-bit glyph bitmap using serpentine row mapping.
- Frames are triggered by a periodic refresh timer or an explicit request.
- Sits between host/config logic and the bit-level strip serializer; words are handed over on a valid/ready stream.

---
 rtl/matrix_frame_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_matrix_frame_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler
// Sequences one APA102-style refresh of an 8x8 LED matrix: one start word,
// 64 pixel words, then END_WORDS end words. Each pixel word is the foreground
// or background colour, chosen from a 64-bit glyph bitmap (bit 63 = glyph
// index 0) with serpentine row mapping. Frames start from a refresh timer,
// an explicit frame_req, or a request that was held pending during a frame.
//
// Optional feature: define MATRIX_SCROLL_EN to add a 3-bit column offset that
// advances once per completed frame, scrolling the glyph one column per frame.
//
// Stream handshake: a word transfers on any clock edge where word_valid and
// word_ready are both high. While word_valid is high and word_ready is low,
// word_data, word_first and word_last hold their values, and word_valid only
// falls after the final end word has transferred.
//
// Debug visibility: the FSM state is held in the 'state' register (state_t).
module matrix_frame_scheduler #(
    parameter int unsigned REFRESH_TICKS = 6000,
    parameter int unsigned END_WORDS     = 2,
    parameter logic [31:0] START_WORD    = 32'h00000000,
    parameter logic [31:0] END_WORD      = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_req,
    input  logic        cfg_we,
    input  logic [63:0] cfg_glyph,
    input  logic [31:0] cfg_fg,
    input  logic [31:0] cfg_bg,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_first,
    output logic        word_last,
    output logic        busy,
    output logic        frame_done
);

    // The refresh counter only ever holds 0..REFRESH_TICKS-1 and the end
    // counter 0..END_WORDS-1, so $clog2 of the limit is wide enough.
    localparam int unsigned CNT_W = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam int unsigned END_W = (END_WORDS > 1) ? $clog2(END_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_TICKS - 1);
    localparam logic [END_W-1:0] END_MAX = END_W'(END_WORDS - 1);
    localparam logic [31:0] RESET_COLOUR = 32'hE0000000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_PIXELS = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] refresh_cnt;
    logic [5:0]       pix_idx;
    logic [END_W-1:0] end_idx;
    logic             pend_flag;
    logic [63:0]      pend_glyph;
    logic [31:0]      pend_fg;
    logic [31:0]      pend_bg;
    logic [63:0]      act_glyph;
    logic [31:0]      act_fg;
    logic [31:0]      act_bg;

    logic             hs;
    logic             trigger;
    logic [5:0]       look_idx;
    logic [2:0]       look_col;
    logic [5:0]       glyph_idx;
    logic [31:0]      pix_word;

`ifdef MATRIX_SCROLL_EN
    logic [2:0]       scroll_off;

    // Column offset advances once per completed frame (wraps mod 8).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_off <= 3'd0;
        end else if (frame_done) begin
            scroll_off <= scroll_off + 3'd1;
        end
    end
`endif

    assign hs      = word_valid && word_ready;
    assign trigger = (refresh_cnt == CNT_MAX) || frame_req || pend_flag;

    // Pixel lookup for the word presented after the current handshake:
    // pixel 0 after the start word, otherwise the next pixel index.
    always_comb begin
        look_idx = (state == S_PIXELS) ? (pix_idx + 6'd1) : 6'd0;
`ifdef MATRIX_SCROLL_EN
        look_col = look_idx[2:0] + scroll_off;
`else
        look_col = look_idx[2:0];
`endif
        // Even rows run right-to-left (7 - c), odd rows left-to-right.
        glyph_idx = look_idx[3] ? {look_idx[5:3], look_col} : {look_idx[5:3], ~look_col};
        pix_word  = act_glyph[6'd63 - glyph_idx] ? act_fg : act_bg;
    end

    // Frame sequencer with registered stream outputs and config staging.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            refresh_cnt <= '0;
            pix_idx     <= 6'd0;
            end_idx     <= '0;
            pend_flag   <= 1'b0;
            pend_glyph  <= 64'd0;
            pend_fg     <= RESET_COLOUR;
            pend_bg     <= RESET_COLOUR;
            act_glyph   <= 64'd0;
            act_fg      <= RESET_COLOUR;
            act_bg      <= RESET_COLOUR;
            word_data   <= 32'd0;
            word_valid  <= 1'b0;
            word_first  <= 1'b0;
            word_last   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cfg_we) begin
                pend_glyph <= cfg_glyph;
                pend_fg    <= cfg_fg;
                pend_bg    <= cfg_bg;
            end
            // Requests arriving mid-frame collapse into one pending frame.
            if (frame_req && (state != S_IDLE)) begin
                pend_flag <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state       <= S_START;
                        refresh_cnt <= '0;
                        pend_flag   <= 1'b0;
                        // A write landing on the start cycle bypasses staging.
                        act_glyph   <= cfg_we ? cfg_glyph : pend_glyph;
                        act_fg      <= cfg_we ? cfg_fg : pend_fg;
                        act_bg      <= cfg_we ? cfg_bg : pend_bg;
                        word_valid  <= 1'b1;
                        word_data   <= START_WORD;
                        word_first  <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        refresh_cnt <= refresh_cnt + CNT_W'(1);
                    end
                end
                S_START: begin
                    if (hs) begin
                        state      <= S_PIXELS;
                        pix_idx    <= 6'd0;
                        word_first <= 1'b0;
                        word_data  <= pix_word;
                    end
                end
                S_PIXELS: begin
                    if (hs) begin
                        if (pix_idx == 6'd63) begin
                            state     <= S_END;
                            end_idx   <= '0;
                            word_data <= END_WORD;
                            word_last <= (END_MAX == '0);
                        end else begin
                            pix_idx   <= pix_idx + 6'd1;
                            word_data <= pix_word;
                        end
                    end
                end
                S_END: begin
                    if (hs) begin
                        if (end_idx == END_MAX) begin
                            state      <= S_IDLE;
                            word_valid <= 1'b0;
                            word_last  <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            end_idx   <= end_idx + END_W'(1);
                            word_last <= ((end_idx + END_W'(1)) == END_MAX);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// tb_matrix_frame_scheduler
// Directed bench for matrix_frame_scheduler (REFRESH_TICKS=10, END_WORDS=2).
// The driver pushes the expected 67-word frames into exp_q as it issues
// stimulus; a negedge monitor pops and compares on every stream handshake,
// checks stall stability, frame length and the frame_done pulse.
// Build with MATRIX_SCROLL_EN defined to model the per-frame column scroll.
module tb_matrix_frame_scheduler;

    localparam int REFRESH_TICKS = 10;
    localparam int END_WORDS     = 2;
    localparam logic [31:0] START_WORD = 32'h00000000;
    localparam logic [31:0] END_WORD   = 32'hFFFFFFFF;
    localparam int FRAME_LEN = 1 + 64 + END_WORDS;

    localparam logic [63:0] G1  = 64'h0000780C7CCC7600;
    localparam logic [31:0] FG1 = 32'hFF0000FF;
    localparam logic [31:0] BG1 = 32'hE0000000;
    localparam logic [63:0] G2  = 64'h8142241818244281;
    localparam logic [31:0] FG2 = 32'hE100FF00;
    localparam logic [31:0] BG2 = 32'hE1000010;
    localparam logic [63:0] G3  = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [31:0] FG3 = 32'hF0F0F0F0;
    localparam logic [31:0] BG3 = 32'hE0101010;

    logic        clk;
    logic        reset;
    logic        frame_req;
    logic        cfg_we;
    logic [63:0] cfg_glyph;
    logic [31:0] cfg_fg;
    logic [31:0] cfg_bg;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        word_first;
    logic        word_last;
    logic        busy;
    logic        frame_done;

    // Expected stream entries: {first, last, data}
    logic [33:0] exp_q[$];
    int          errors;
    int          checks;
    int          frame_num;

    matrix_frame_scheduler #(
        .REFRESH_TICKS(REFRESH_TICKS),
        .END_WORDS    (END_WORDS),
        .START_WORD   (START_WORD),
        .END_WORD     (END_WORD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_req (frame_req),
        .cfg_we    (cfg_we),
        .cfg_glyph (cfg_glyph),
        .cfg_fg    (cfg_fg),
        .cfg_bg    (cfg_bg),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_first(word_first),
        .word_last (word_last),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // Pixel p -> row r, column c (plus scroll), serpentine glyph index g.
    function automatic logic [31:0] model_pixel(input logic [63:0] glyph, input logic [31:0] fg,
                                                input logic [31:0] bg, input int p, input int off);
        int r;
        int c;
        int g;
        r = p / 8;
        c = ((p % 8) + off) % 8;
        if ((r % 2) == 0) g = 8 * r + 7 - c;
        else              g = 8 * r + c;
        return glyph[63 - g] ? fg : bg;
    endfunction

    task automatic push_frame(input logic [63:0] glyph, input logic [31:0] fg, input logic [31:0] bg);
        int off;
`ifdef MATRIX_SCROLL_EN
        off = frame_num % 8;
`else
        off = 0;
`endif
        exp_q.push_back({1'b1, 1'b0, START_WORD});
        for (int p = 0; p < 64; p++) begin
            exp_q.push_back({1'b0, 1'b0, model_pixel(glyph, fg, bg, p, off)});
        end
        for (int e = 0; e < END_WORDS; e++) begin
            exp_q.push_back({1'b0, (e == END_WORDS - 1), END_WORD});
        end
        frame_num++;
    endtask

    // Returns on the first rising edge where at most 'target' entries remain.
    task automatic wait_size(input int target, input string name);
        int cyc;
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk);
            cyc++;
            if (exp_q.size() <= target) return;
        end
        timeout(name);
    endtask

    // Counts rising edges until word_valid is seen (sampled 1 time unit later).
    task automatic count_to_valid(output int n);
        n = 0;
        #1;
        while (!word_valid && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic        stall_prev;
    logic [33:0] prev_word;
    logic        done_due;
    int          hs_cnt;
    logic [33:0] exp_word;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
            done_due   = 1'b0;
            hs_cnt     = 0;
        end else begin
            if (done_due) begin
                check("frame_done_pulse", 64'(frame_done), 64'd1);
                done_due = 1'b0;
            end else if (frame_done) begin
                check("frame_done_spurious", 64'(frame_done), 64'd0);
            end
            if (stall_prev) begin
                check("stall_valid", 64'(word_valid), 64'd1);
                check("stall_hold", 64'({word_first, word_last, word_data}), 64'(prev_word));
            end
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'({word_first, word_last, word_data}), 64'd0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check($sformatf("word_%0d", hs_cnt), 64'({word_first, word_last, word_data}),
                          64'(exp_word));
                    if (exp_word[33]) hs_cnt = 1;
                    else              hs_cnt++;
                    if (exp_word[32]) begin
                        check("frame_handshakes", 64'(hs_cnt), 64'(FRAME_LEN));
                        done_due = 1'b1;
                    end
                end
            end
            stall_prev = word_valid && !word_ready;
            prev_word  = {word_first, word_last, word_data};
        end
    end

    // ---------------- driver ----------------
    initial begin
        int n;
        int v;
        int cyc;
        errors     = 0;
        checks     = 0;
        frame_num  = 0;
        reset      = 1'b1;
        frame_req  = 1'b0;
        cfg_we     = 1'b0;
        cfg_glyph  = 64'd0;
        cfg_fg     = 32'd0;
        cfg_bg     = 32'd0;
        word_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_first", 64'(word_first), 64'd0);
        check("rst_last", 64'(word_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_data", 64'(word_data), 64'd0);

        // Timer frame: glyph written right after release, first word 10 cycles later
        @(posedge clk);
        #1;
        reset     = 1'b0;
        cfg_we    = 1'b1;
        cfg_glyph = G1;
        cfg_fg    = FG1;
        cfg_bg    = BG1;
        push_frame(G1, FG1, BG1);
        @(posedge clk);
        n = 1;
        #1;
        cfg_we = 1'b0;
        while (!word_valid && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("timer_latency", 64'(n), 64'(REFRESH_TICKS));
        check("busy_in_frame", 64'(busy), 64'd1);
        // Zero bubbles with word_ready held high
        v = 0;
        while (word_valid && v < 200) begin
            v++;
            @(posedge clk);
            #1;
        end
        check("contiguous_words", 64'(v), 64'(FRAME_LEN));
        wait_size(0, "drain_t1");

        // Two frames under a pseudo-random ready pattern
        push_frame(G1, FG1, BG1);
        push_frame(G1, FG1, BG1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            word_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        word_ready = 1'b1;
        if (cyc >= 3000) timeout("drain_stall");

        // Config written mid-frame only affects the following frame
        push_frame(G1, FG1, BG1);
        push_frame(G2, FG2, BG2);
        wait_size(2 * FRAME_LEN - 20, "mid_frame");
        #1;
        cfg_we    = 1'b1;
        cfg_glyph = G2;
        cfg_fg    = FG2;
        cfg_bg    = BG2;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        wait_size(0, "drain_t3");

        // cfg_we coincident with a frame_req trigger loads straight into the frame
        push_frame(G3, FG3, BG3);
        #1;
        frame_req = 1'b1;
        cfg_we    = 1'b1;
        cfg_glyph = G3;
        cfg_fg    = FG3;
        cfg_bg    = BG3;
        @(posedge clk);
        #1;
        frame_req = 1'b0;
        cfg_we    = 1'b0;
        check("req_latency", 64'(word_valid), 64'd1);
        check("req_first", 64'(word_first), 64'd1);
        wait_size(0, "drain_t4");

        // Three requests during a frame collapse into one immediate extra frame
        push_frame(G3, FG3, BG3);
        push_frame(G3, FG3, BG3);
        push_frame(G3, FG3, BG3);
        n = 0;
        while (!busy && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("busy_seen", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            frame_req = 1'b1;
            @(posedge clk);
            #1;
            frame_req = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_size(2 * FRAME_LEN, "pending_frame");
        count_to_valid(n);
        check("pending_latency", 64'(n), 64'd1);
        wait_size(FRAME_LEN, "after_pending");
        count_to_valid(n);
        check("timer_restart", 64'(n), 64'(REFRESH_TICKS));

        // Reset while pixel 30 is presented
        wait_size(FRAME_LEN - 31, "pixel_30");
        #1;
        reset = 1'b1;
        #1;
        check("async_valid", 64'(word_valid), 64'd0);
        check("async_data", 64'(word_data), 64'd0);
        check("async_first", 64'(word_first), 64'd0);
        check("async_last", 64'(word_last), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_done", 64'(frame_done), 64'd0);
        exp_q.delete();
        frame_num = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Config registers are back at reset values: all pixels background
        push_frame(64'd0, 32'hE0000000, 32'hE0000000);
        count_to_valid(n);
        check("post_reset_latency", 64'(n), 64'(REFRESH_TICKS));
        check("post_reset_first", 64'(word_first), 64'd1);
        wait_size(0, "drain_t6");
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
